// File: rtl/ctrl_fsm_pkg.sv
// rtl/ctrl_fsm_pkg.sv - shared types and opcode classification for the RV32I sequencer
package ctrl_fsm_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    SRC_PC_PLUS4, SRC_PC2, SRC_ALU, SRC_MEM, SRC_RF, SRC_CNTR
  } src_t;

  typedef enum logic [1:0] {X0, RS1, RS2, RD} regnum_t;

  typedef enum logic [2:0] {
    S_FETCH, S_RS1, S_RS2, S_EXEC, S_TARGET, S_MEM, S_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic    set_ir;
    logic    set_pc;
    logic    set_pc2;
    logic    set_r1;
    logic    set_r2;
    logic    start;
    logic    alu_op;
    logic    alu_a_r1;
    logic    alu_b_r2;
    logic    r2_src;
    logic    memop;
    regnum_t rf_regnum_src;
    src_t    maddr_src;
    src_t    pc_src;
    src_t    r1_src;
    src_t    rf_src;
  } ctrl_t;

  typedef struct packed {
    logic needs_rs2;
    logic writes_rd;
    logic is_mem;
  } op_class_t;

  // Coarse instruction class; unknown opcodes come back all-zero.
  function automatic op_class_t classify(opcode_t op);
    op_class_t c;
    c.needs_rs2 = (op == OP_OP) || (op == OP_BRANCH) || (op == OP_STORE);
    c.writes_rd = (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) ||
                  (op == OP_JALR) || (op == OP_IMM) || (op == OP_OP) ||
                  (op == OP_LOAD) || (op == OP_SYSTEM);
    c.is_mem    = (op == OP_LOAD) || (op == OP_STORE);
    return c;
  endfunction

endpackage

// File: rtl/ctrl_fsm_decode.sv
// rtl/ctrl_fsm_decode.sv - combinational opcode to control-class decode
module ctrl_decode
  import ctrl_fsm_pkg::*;
(
  input  opcode_t opcode,
  input  logic    f3_is_csr,
  output logic    to_rs2,
  output logic    to_exec,
  output logic    to_wb,
  output logic    is_jump,
  output logic    is_branch,
  output logic    is_load,
  output logic    is_store,
  output logic    is_mem,
  output logic    multi_pass,
  output logic    alu_op,
  output logic    alu_a_r1,
  output logic    alu_b_r2,
  output src_t    wb_src
);

  op_class_t cls;

  // Class bits; anything not reaching RS2, EXEC or WB from RS1 is illegal.
  always_comb begin
    cls        = classify(opcode);
    to_rs2     = cls.needs_rs2;
    to_exec    = cls.writes_rd && !cls.needs_rs2 && (opcode != OP_SYSTEM);
    to_wb      = (opcode == OP_SYSTEM) && f3_is_csr;
    is_jump    = (opcode == OP_JAL) || (opcode == OP_JALR);
    is_branch  = (opcode == OP_BRANCH);
    is_load    = (opcode == OP_LOAD);
    is_store   = (opcode == OP_STORE);
    is_mem     = cls.is_mem;
    multi_pass = (opcode == OP_OP) || (opcode == OP_IMM);
    alu_op     = (opcode == OP_OP) || (opcode == OP_IMM) || (opcode == OP_BRANCH);
    alu_a_r1   = !((opcode == OP_AUIPC) || (opcode == OP_JAL));
    alu_b_r2   = (opcode == OP_OP) || (opcode == OP_BRANCH);
    if (is_jump)                   wb_src = SRC_PC_PLUS4;
    else if (opcode == OP_SYSTEM)  wb_src = SRC_CNTR;
    else if (is_load)              wb_src = SRC_MEM;
    else                           wb_src = SRC_ALU;
  end

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle RV32I control sequencer
module ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter bit FETCH_AFTER_RESET = 1'b0
) (
  input  logic    clk,
  input  logic    rst,
  input  opcode_t opcode,
  input  logic    f3_is_csr,
  input  logic    done,
  input  logic    branch_taken,
  input  logic    mem_ready,
  output ctrl_t   ctrl,
  output logic    rf_we,
  output logic    mem_req,
  output logic    mem_we,
  output logic    trap,
  output state_t  state_dbg
);

  localparam state_t RESET_STATE = FETCH_AFTER_RESET ? S_FETCH : S_RS1;

  state_t state, state_n;
  logic   redirect, redirect_n;
  logic   trap_n;
  logic   start_pending;

  logic to_rs2, to_exec, to_wb, is_jump, is_branch, is_load, is_store, is_mem;
  logic multi_pass, alu_op, alu_a_r1, alu_b_r2;
  src_t wb_src;

  ctrl_decode u_decode (
    .opcode     (opcode),
    .f3_is_csr  (f3_is_csr),
    .to_rs2     (to_rs2),
    .to_exec    (to_exec),
    .to_wb      (to_wb),
    .is_jump    (is_jump),
    .is_branch  (is_branch),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_mem     (is_mem),
    .multi_pass (multi_pass),
    .alu_op     (alu_op),
    .alu_a_r1   (alu_a_r1),
    .alu_b_r2   (alu_b_r2),
    .wb_src     (wb_src)
  );

  // State, redirect, trap and the one-shot start flag; start re-arms on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RESET_STATE;
      redirect      <= 1'b1;
      trap          <= 1'b0;
      start_pending <= 1'b1;
    end else begin
      state         <= state_n;
      redirect      <= redirect_n;
      trap          <= trap_n;
      start_pending <= (state_n != state);
    end
  end

  // Next state and control outputs; everything is forced quiet while rst is high.
  always_comb begin
    state_n    = state;
    redirect_n = redirect;
    trap_n     = trap;
    ctrl       = '0;
    rf_we      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req        = 1'b1;
        ctrl.maddr_src = redirect ? SRC_PC2 : SRC_PC_PLUS4;
        ctrl.pc_src    = redirect ? SRC_PC2 : SRC_PC_PLUS4;
        if (mem_ready) begin
          ctrl.set_ir = 1'b1;
          ctrl.set_pc = 1'b1;
          redirect_n  = 1'b0;
          state_n     = S_RS1;
        end
      end
      S_RS1: begin
        ctrl.rf_regnum_src = RS1;
        ctrl.set_r1        = 1'b1;
        ctrl.r1_src        = SRC_RF;
        if (to_rs2)       state_n = S_RS2;
        else if (to_exec) state_n = S_EXEC;
        else if (to_wb)   state_n = S_WB;
        else begin
          state_n = S_HALT;
          trap_n  = 1'b1;
        end
      end
      S_RS2: begin
        ctrl.rf_regnum_src = RS2;
        ctrl.set_r2        = 1'b1;
        ctrl.r2_src        = 1'b1;
        state_n            = S_EXEC;
      end
      S_EXEC: begin
        ctrl.start    = start_pending;
        ctrl.alu_op   = alu_op;
        ctrl.alu_a_r1 = alu_a_r1;
        ctrl.alu_b_r2 = alu_b_r2;
        if (done) begin
          if (is_jump) begin
            ctrl.set_pc2 = 1'b1;
            redirect_n   = 1'b1;
            state_n      = S_WB;
          end else if (is_branch) begin
            state_n = branch_taken ? S_TARGET : S_FETCH;
          end else if (is_mem) begin
            state_n = S_MEM;
          end else begin
            state_n = S_WB;
          end
        end else if (multi_pass && !start_pending) begin
          // Iterative shifts reload the remaining shift amount into r2 each pass.
          ctrl.set_r2 = 1'b1;
          ctrl.r2_src = 1'b0;
        end
      end
      S_TARGET: begin
        ctrl.start = start_pending;
        if (done) begin
          ctrl.set_pc2 = 1'b1;
          redirect_n   = 1'b1;
          state_n      = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req        = 1'b1;
        mem_we         = is_store;
        ctrl.memop     = 1'b1;
        ctrl.maddr_src = SRC_ALU;
        if (is_store) ctrl.rf_regnum_src = RS2;
        if (mem_ready) begin
          if (is_load) begin
            ctrl.set_r1 = 1'b1;
            ctrl.r1_src = SRC_MEM;
            state_n     = S_WB;
          end else begin
            state_n = S_FETCH;
          end
        end
      end
      S_WB: begin
        ctrl.rf_regnum_src = RD;
        ctrl.rf_src        = wb_src;
        rf_we              = 1'b1;
        state_n            = S_FETCH;
      end
      default: begin
        state_n = S_HALT;
      end
    endcase
    if (rst) begin
      ctrl    = '0;
      rf_we   = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/ctrl_fsm.md
Name: ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32I datapath.
- Each cycle it drives the ctrl_t bundle from the current opcode, ALU done and branch_taken.
- It runs each instruction through fetch, register read, execute, memory and writeback.
- It also handles the memory ready/request handshake, the register-file write enable and illegal-opcode trapping.

Parameters:
- FETCH_AFTER_RESET, 0: 0 = first executes the reset-seeded IR (OP_JALR) from S_RS1; 1 = starts in S_FETCH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- opcode  in  opcode_t  from datapath, decoded from IR
- f3_is_csr  in  1  SYSTEM instruction is a counter read (CSRRS, rs1=x0)
- done  in  1  ALU result valid
- branch_taken  in  1  branch compare result
- mem_ready  in  1  memory accepts/completes the current request this cycle
- ctrl  out  ctrl_t  datapath control bundle
- rf_we  out  1  register-file write strobe
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a store
- trap  out  1  sticky illegal-instruction flag
- state_dbg  out  state_t  current state, for the bench

Behaviour:
- States: S_FETCH, S_RS1, S_RS2, S_EXEC, S_TARGET, S_MEM, S_WB, S_HALT.
- Default ctrl: all set_* = 0, start = 0, alu_op = 0, alu_a_r1 = 0, alu_b_r2 = 0, rf_regnum_src = X0, memop = 0.
- Reset: state = S_RS1 (or S_FETCH if FETCH_AFTER_RESET), redirect = 1, trap = 0, start_pending = 1. All strobes are 0 in the reset cycle.
- S_FETCH:
  - mem_req = 1, mem_we = 0, memop = 0.
  - maddr_src = pc_src = (redirect ? SRC_PC2 : SRC_PC_PLUS4).
  - set_ir and set_pc assert only in the cycle mem_ready = 1; that cycle also clears redirect and moves to S_RS1. Otherwise hold.
- S_RS1:
  - rf_regnum_src = RS1, set_r1 = 1, r1_src = SRC_RF.
  - Next state: OP, BRANCH or STORE -> S_RS2; LUI, AUIPC, JAL, JALR, IMM, LOAD -> S_EXEC; SYSTEM with f3_is_csr -> S_WB; anything else -> S_HALT with trap = 1.
- S_RS2: rf_regnum_src = RS2, set_r2 = 1, r2_src = 1 -> S_EXEC.
- S_EXEC:
  - start = 1 on the entry cycle only, tracked by the start_pending flop.
  - alu_op = 1 for OP, IMM and BRANCH.
  - alu_a_r1 = 1 except AUIPC and JAL.
  - alu_b_r2 = 1 for OP and BRANCH.
  - Hold until done. While r2 reloads the shift amount for multi-pass shifts (set_r2 = 1, r2_src = 0), continue to hold.
  - On done: JAL/JALR -> set_pc2 = 1, redirect <= 1, go S_WB. BRANCH -> S_TARGET if branch_taken, else S_FETCH. LOAD/STORE -> S_MEM. Others -> S_WB.
- S_TARGET: start on entry, alu_op = 0, alu_a_r1 = 0; on done set_pc2 = 1, redirect <= 1 -> S_FETCH.
- S_MEM:
  - mem_req = 1, memop = 1, maddr_src = SRC_ALU, mem_we = (opcode == OP_STORE).
  - Stores drive rf_regnum_src = RS2.
  - Wait for mem_ready. On that cycle a load sets set_r1 with r1_src = SRC_MEM -> S_WB; a store -> S_FETCH.
- S_WB:
  - rf_regnum_src = RD, rf_we = 1 for exactly one cycle -> S_FETCH.
  - rf_src: SRC_PC_PLUS4 for JAL/JALR, SRC_CNTR for SYSTEM, SRC_MEM for LOAD, SRC_ALU otherwise.
  - The datapath rf mux passes memread_data on SRC_MEM (companion change).
- S_HALT: absorbing; all strobes 0; trap held until rst.
- rd = x0 writes still pulse rf_we; the register file discards them.
- rst mid-operation (any state, including mem_req pending): next cycle is the reset state; mem_req is dropped with no completion expected.
- mem_ready outside S_FETCH/S_MEM is ignored. done outside S_EXEC/S_TARGET is ignored.

Decomposition:
- Shared package (next to ctrl_t, src_t, opcode_t): state_t enum; a function mapping opcode to needs_rs2 / writes_rd / is_mem.
- Sub-module ctrl_decode (combinational opcode -> class bits) is natural.
- Sequential logic (state, redirect, start_pending, trap) stays in ctrl_fsm.

Test Plan:
- Reset, then ADD x3,x1,x2 (x1 = 5, x2 = 7), mem_ready always 1 -> sequence FETCH, RS1, RS2, EXEC, WB; rf_we pulses once; x3 = 12; next fetch uses SRC_PC_PLUS4.
- BEQ with r1 = r2 = 9 -> EXEC then TARGET; set_pc2 pulses; next FETCH uses SRC_PC2. Not-taken variant goes EXEC -> FETCH with SRC_PC_PLUS4.
- LW with mem_ready low for 3 cycles in S_MEM -> mem_req held 4 cycles, set_r1 only on the ready cycle, then WB with rf_src = SRC_MEM.
- SW -> mem_we = 1 in S_MEM, rf_we never asserts, returns to FETCH.
- Opcode 7'b1111111 -> S_HALT, trap = 1 stays set; rst clears it to 0.
- Assert rst while in S_EXEC with done low -> next cycle state_dbg = S_RS1; start re-pulses on the next EXEC entry.
